mem_arbiter: RTL and testbench

Shares one single-ported, wait-stated unified memory bus between the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage side) of the openmips core. It serialises the two requests with round-robin priority and holds each request's result until the pipeline advances. It drives a stall request into ctrl and aborts transactions that hang past a timeout.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported, wait-stated memory bus between the instruction
//   fetch master (pc_reg/if_id) and the data master (mem stage). Requests are
//   serialised with round-robin priority. Each completed result is held, and
//   its master is marked done, until the pipeline advances. A transaction
//   that gets no ack within TIMEOUT cycles is aborted with a bus_err_o pulse.
//
// Ports
//   clk, rst           : clock, asynchronous active-low reset
//   inst_ce_i/addr_i   : fetch request (held until the pipeline advances)
//   inst_data_o        : fetched word (registered)
//   data_ce/we/sel/addr/wdata_i : data access request
//   data_rdata_o       : read data (registered)
//   hold_i             : pipeline frozen by another stall source
//   stallreq_o         : a requested access has not completed yet
//   bus_err_o          : one-cycle pulse on timeout abort
//   mem_*_o            : registered memory bus request
//   mem_rdata_i/ack_i  : memory response, ack is a one-cycle strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_ce_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [DATA_W-1:0] inst_data_o,
   input  logic              data_ce_i,
   input  logic              data_we_i,
   input  logic [3:0]        data_sel_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic [DATA_W-1:0] data_rdata_o,
   input  logic              hold_i,
   output logic              stallreq_o,
   output logic              bus_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA} state_t;

   // Abort fires on the edge where the counter already sits at TIMEOUT-1,
   // so mem_req_o stays high for exactly TIMEOUT cycles without an ack.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     r_state, w_next;
   logic       r_inst_done, r_data_done;
   logic       r_last_data;            // last grant went to DATA (reset: INST)
   logic [7:0] r_cnt;

   logic       w_pend_i, w_pend_d, w_stall;
   logic       w_grant_i, w_grant_d;
   logic       w_ack, w_abort, w_finish;
   logic       w_release;

   assign w_pend_i  = inst_ce_i & ~r_inst_done;
   assign w_pend_d  = data_ce_i & ~r_data_done;
   assign w_stall   = w_pend_i | w_pend_d;
   // Gated by reset so every output reads 0 while rst is asserted.
   assign stallreq_o = rst & w_stall;
   // Pipeline advances on this edge: completed results have been consumed.
   assign w_release = ~w_stall & ~hold_i;
   assign w_finish  = w_ack | w_abort;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      w_ack     = 1'b0;
      w_abort   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // mem_ack_i is ignored here; only pending requests matter.
            if (w_pend_i && w_pend_d) begin
               if (r_last_data) w_grant_i = 1'b1;
               else             w_grant_d = 1'b1;
            end else if (w_pend_i) begin
               w_grant_i = 1'b1;
            end else if (w_pend_d) begin
               w_grant_d = 1'b1;
            end
            if (w_grant_i) w_next = S_INST;
            if (w_grant_d) w_next = S_DATA;
         end
         S_INST, S_DATA: begin
            // Always return to IDLE: guarantees one idle cycle between grants.
            if (mem_ack_i) begin
               w_ack  = 1'b1;
               w_next = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_abort = 1'b1;
               w_next  = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------- bus request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= 4'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         r_cnt       <= '0;
         r_last_data <= 1'b0;
         bus_err_o   <= 1'b0;
      end else begin
         bus_err_o <= w_abort;
         if (w_grant_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_sel_o   <= 4'b1111;
            mem_addr_o  <= inst_addr_i;
            mem_wdata_o <= '0;
            r_cnt       <= '0;
            r_last_data <= 1'b0;
         end else if (w_grant_d) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_sel_o   <= data_sel_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
            r_cnt       <= '0;
            r_last_data <= 1'b1;
         end else if (r_state != S_IDLE) begin
            // Address/data stay put; only the request strobe drops on finish.
            if (w_finish) mem_req_o <= 1'b0;
            else          r_cnt     <= r_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------ result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_data_o  <= '0;
         data_rdata_o <= '0;
      end else begin
         if (r_state == S_INST && w_finish)
            inst_data_o <= w_ack ? mem_rdata_i : '0;
         // A write ack leaves the read-data register alone; an abort always
         // loads 0 so the pipeline never consumes stale data.
         if (r_state == S_DATA && (w_abort || (w_ack && !mem_we_o)))
            data_rdata_o <= w_ack ? mem_rdata_i : '0;
      end
   end

   // ------------------------------------------------------------ done flags
   // A done flag keeps a finished access from being re-issued while its
   // request is still presented (pipeline stalled or held). Setting wins
   // over release in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inst_done <= 1'b0;
         r_data_done <= 1'b0;
      end else begin
         r_inst_done <= (r_inst_done & ~w_release) | (r_state == S_INST && w_finish);
         r_data_done <= (r_data_done & ~w_release) | (r_state == S_DATA && w_finish);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed vector table (one record per clock cycle: inputs plus expected
//   outputs) followed by hand-written multi-cycle sequences: round-robin,
//   timeout abort, hold_i interaction and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_ce_i = 1'b0;
   logic [31:0] inst_addr_i = '0;
   logic [31:0] inst_data_o;
   logic        data_ce_i = 1'b0;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_sel_i = '0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic [31:0] data_rdata_o;
   logic        hold_i = 1'b0;
   logic        stallreq_o;
   logic        bus_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
      .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
      .hold_i(hold_i), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   typedef struct {
      logic        rst, ice;
      logic [31:0] iaddr;
      logic        dce, dwe;
      logic [3:0]  dsel;
      logic [31:0] daddr, dwd;
      logic        hold, ack;
      logic [31:0] rd;
      logic        ereq, ewe;
      logic [3:0]  esel;
      logic [31:0] eaddr, ewd;
      logic        estall;
      logic [31:0] eidata, edrd;
      logic        eberr;
   } vec_t;

   vec_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic v(input logic r, input logic ice, input logic [31:0] iaddr,
                    input logic dce, input logic dwe, input logic [3:0] dsel,
                    input logic [31:0] daddr, input logic [31:0] dwd,
                    input logic hold, input logic ack, input logic [31:0] rd,
                    input logic ereq, input logic ewe, input logic [3:0] esel,
                    input logic [31:0] eaddr, input logic [31:0] ewd,
                    input logic estall, input logic [31:0] eidata,
                    input logic [31:0] edrd, input logic eberr);
      vec_t t;
      t.rst = r;  t.ice = ice;  t.iaddr = iaddr;
      t.dce = dce; t.dwe = dwe; t.dsel = dsel; t.daddr = daddr; t.dwd = dwd;
      t.hold = hold; t.ack = ack; t.rd = rd;
      t.ereq = ereq; t.ewe = ewe; t.esel = esel; t.eaddr = eaddr; t.ewd = ewd;
      t.estall = estall; t.eidata = eidata; t.edrd = edrd; t.eberr = eberr;
      q.push_back(t);
   endtask

   // Wait (bounded) for the next bus request, check it, then ack it once.
   task automatic serve(input string nm, input logic [31:0] addr, input logic we,
                        input logic [31:0] rd);
      int k = 0;
      while (!mem_req_o && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_req"}, mem_req_o, 1'b1);
      chk({nm, "_addr"}, mem_addr_o, addr);
      chk({nm, "_we"}, mem_we_o, we);
      mem_ack_i   = 1'b1;
      mem_rdata_i = rd;
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
   endtask

   initial begin
      // ------------------------------------------------ vector table
      // reset
      v(0, 0,0,     0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 0,0, 0);
      v(0, 0,0,     0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 0,0, 0);
      // single fetch 0x100, ack in the third request cycle
      v(1, 1,'h100, 0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   1, 0,0, 0);
      v(1, 1,'h100, 0,0,0,0,0,                       0,0,0,            1,0,4'hF,'h100,0,            1, 0,0, 0);
      v(1, 1,'h100, 0,0,0,0,0,                       0,0,0,            1,0,4'hF,'h100,0,            1, 0,0, 0);
      v(1, 1,'h100, 0,0,0,0,0,                       0,1,'h3C010001,   1,0,4'hF,'h100,0,            1, 0,0, 0);
      v(1, 1,'h100, 0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 'h3C010001,0, 0);
      v(1, 0,0,     0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 'h3C010001,0, 0);
      // reset clears the result register
      v(0, 0,0,     0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 0,0, 0);
      // simultaneous fetch 0x104 + write 0x2000: DATA first, then INST
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,0,0,            0,0,0,0,0,                   1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,0,0,            1,1,4'h3,'h2000,'hDEADBEEF,  1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,1,'h12345678,   1,1,4'h3,'h2000,'hDEADBEEF,  1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,0,0,            0,0,0,0,0,                   1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,0,0,            1,0,4'hF,'h104,0,            1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,1,'h24020005,   1,0,4'hF,'h104,0,            1, 0,0, 0);
      v(1, 1,'h104, 1,1,4'h3,'h2000,'hDEADBEEF,      0,0,0,            0,0,0,0,0,                   0, 'h24020005,0, 0);
      v(1, 0,0,     0,0,0,0,0,                       0,0,0,            0,0,0,0,0,                   0, 'h24020005,0, 0);

      foreach (q[i]) begin
         @(negedge clk);
         rst = q[i].rst;
         inst_ce_i = q[i].ice;  inst_addr_i = q[i].iaddr;
         data_ce_i = q[i].dce;  data_we_i = q[i].dwe;  data_sel_i = q[i].dsel;
         data_addr_i = q[i].daddr; data_wdata_i = q[i].dwd;
         hold_i = q[i].hold; mem_ack_i = q[i].ack; mem_rdata_i = q[i].rd;
         #1;
         chk($sformatf("v%0d_req", i), mem_req_o, q[i].ereq);
         if (q[i].ereq) begin
            chk($sformatf("v%0d_we", i), mem_we_o, q[i].ewe);
            chk($sformatf("v%0d_sel", i), mem_sel_o, q[i].esel);
            chk($sformatf("v%0d_addr", i), mem_addr_o, q[i].eaddr);
            chk($sformatf("v%0d_wdata", i), mem_wdata_o, q[i].ewd);
         end
         chk($sformatf("v%0d_stall", i), stallreq_o, q[i].estall);
         chk($sformatf("v%0d_idata", i), inst_data_o, q[i].eidata);
         chk($sformatf("v%0d_drdata", i), data_rdata_o, q[i].edrd);
         chk($sformatf("v%0d_berr", i), bus_err_o, q[i].eberr);
      end
      mem_ack_i = 1'b0; mem_rdata_i = '0;

      // ------------------------------------------------ round-robin
      // Last grant was INST; a lone data read moves it to DATA, so the
      // next both-pending round must start with INST.
      @(negedge clk);
      data_ce_i = 1; data_we_i = 0; data_sel_i = 4'hF; data_addr_i = 'h3000;
      serve("rr_lone_data", 'h3000, 0, 'hA5A50001);
      #1;
      chk("rr_lone_rdata", data_rdata_o, 'hA5A50001);
      chk("rr_lone_stall", stallreq_o, 0);
      @(negedge clk); data_ce_i = 0;
      @(negedge clk);
      inst_ce_i = 1; inst_addr_i = 'h108;
      data_ce_i = 1; data_addr_i = 'h3004;
      serve("rr_first_inst", 'h108, 0, 'h00001108);
      serve("rr_second_data", 'h3004, 0, 'h0BADF00D);
      #1;
      chk("rr_idata", inst_data_o, 'h00001108);
      chk("rr_drdata", data_rdata_o, 'h0BADF00D);
      chk("rr_stall", stallreq_o, 0);
      @(negedge clk); inst_ce_i = 0; data_ce_i = 0;

      // ------------------------------------------------ timeout (TIMEOUT=4)
      @(negedge clk);
      data_ce_i = 1; data_we_i = 0; data_addr_i = 'h4000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("to_req_c%0d", i), mem_req_o, 1);
         chk($sformatf("to_berr_c%0d", i), bus_err_o, 0);
      end
      @(negedge clk);
      chk("to_req_drop", mem_req_o, 0);
      chk("to_berr_pulse", bus_err_o, 1);
      chk("to_rdata_zero", data_rdata_o, 0);
      #1 chk("to_stall_release", stallreq_o, 0);
      @(negedge clk); data_ce_i = 0;
      chk("to_berr_end", bus_err_o, 0);

      // ------------------------------------------------ hold_i
      // Last grant DATA (the aborted read), so INST goes first.
      @(negedge clk);
      hold_i = 1;
      inst_ce_i = 1; inst_addr_i = 'h200;
      data_ce_i = 1; data_we_i = 0; data_addr_i = 'h5000;
      serve("hold_inst", 'h200, 0, 'h11111111);
      serve("hold_data", 'h5000, 0, 'h22222222);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("hold_noreq_c%0d", i), mem_req_o, 0);
         chk($sformatf("hold_stall_c%0d", i), stallreq_o, 0);
         @(negedge clk);
      end
      hold_i = 0;
      @(negedge clk);
      inst_addr_i = 'h204; data_ce_i = 0;
      serve("hold_new_fetch", 'h204, 0, 'h33333333);
      chk("hold_new_idata", inst_data_o, 'h33333333);
      chk("hold_drdata_kept", data_rdata_o, 'h22222222);
      @(negedge clk); inst_ce_i = 0;

      // ------------------------------------------------ reset mid-transaction
      @(negedge clk);
      data_ce_i = 1; data_we_i = 1; data_sel_i = 4'hC;
      data_addr_i = 'h6000; data_wdata_i = 'hCAFEF00D;
      @(negedge clk);
      chk("rstm_req_before", mem_req_o, 1);
      chk("rstm_we_before", mem_we_o, 1);
      #2 rst = 0;
      #1;
      chk("rstm_req", mem_req_o, 0);
      chk("rstm_we", mem_we_o, 0);
      chk("rstm_sel", mem_sel_o, 0);
      chk("rstm_addr", mem_addr_o, 0);
      chk("rstm_wdata", mem_wdata_o, 0);
      chk("rstm_idata", inst_data_o, 0);
      chk("rstm_drdata", data_rdata_o, 0);
      chk("rstm_berr", bus_err_o, 0);
      chk("rstm_stall", stallreq_o, 0);
      data_ce_i = 0; data_we_i = 0; data_sel_i = 4'hF; data_wdata_i = '0;
      @(negedge clk); rst = 1;
      // Arbitration state is back to reset: both pending -> DATA first.
      inst_ce_i = 1; inst_addr_i = 'h300;
      data_ce_i = 1; data_addr_i = 'h7000;
      serve("rstm_first_data", 'h7000, 0, 'h77770000);
      serve("rstm_then_inst", 'h300, 0, 'h30000000);
      chk("rstm_final_idata", inst_data_o, 'h30000000);
      chk("rstm_final_drdata", data_rdata_o, 'h77770000);
      @(negedge clk); inst_ce_i = 0; data_ce_i = 0;
      @(negedge clk);
      chk("final_idle_req", mem_req_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
